// File: rtl/mc_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute,
// with a retired-instruction counter and a sticky illegal-instruction flag.
module mc_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pc_en,
  output logic [1:0]  pc_src,
  output logic        i_or_d,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_wen,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic [3:0]  state,
  output logic [31:0] instr_count,
  output logic        illegal
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  REXEC  = 4'd6,  RWB   = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  IEXEC  = 4'd10, IWB   = 4'd11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] count_q;
  logic        illegal_q;
  logic        illegal_exit;
  logic        funct_ok;
  logic [3:0]  rexec_op;
  logic        pc_write, pc_write_cond;
  logic        mem_wen_raw, reg_wen_raw, ir_write_raw;

  always_comb begin
    funct_ok = 1'b1;
    rexec_op = 4'd0;
    case (funct)
      6'h20:   rexec_op = 4'd2;
      6'h22:   rexec_op = 4'd6;
      6'h24:   rexec_op = 4'd0;
      6'h25:   rexec_op = 4'd1;
      6'h2A:   rexec_op = 4'd7;
      6'h27:   rexec_op = 4'd12;
      default: funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= FETCH;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Any return to FETCH retires an instruction, including illegal exits.
      if (state_d == FETCH && state_q != FETCH)
        count_q <= count_q + 32'd1;
      if (illegal_exit)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = FETCH;
    illegal_exit = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (opcode)
          6'h23, 6'h2B: state_d = MEMADR;
          6'h00:        state_d = REXEC;
          6'h04:        state_d = BRANCH;
          6'h02:        state_d = JUMP;
          6'h08:        state_d = IEXEC;
          default: begin
            state_d      = FETCH;
            illegal_exit = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (opcode == 6'h2B) ? MEMWR : MEMRD;
      MEMRD:  state_d = MEMWB;
      REXEC: begin
        if (funct_ok) state_d = RWB;
        else          illegal_exit = 1'b1;
      end
      IEXEC:  state_d = IWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'd0;
    i_or_d        = 1'b0;
    mem_ren       = 1'b0;
    mem_wen_raw   = 1'b0;
    ir_write_raw  = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_wen_raw   = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 4'd0;
    case (state_q)
      FETCH: begin
        mem_ren      = 1'b1;
        ir_write_raw = 1'b1;
        alu_src_b    = 2'd1;
        alu_op       = 4'd2;
        pc_write     = 1'b1;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = 4'd2;
      end
      MEMADR, IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = 4'd2;
      end
      MEMRD: begin
        mem_ren = 1'b1;
        i_or_d  = 1'b1;
      end
      MEMWB: begin
        reg_wen_raw = 1'b1;
        mem_to_reg  = 1'b1;
      end
      MEMWR: begin
        mem_wen_raw = 1'b1;
        i_or_d      = 1'b1;
      end
      REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = rexec_op;
      end
      RWB: begin
        reg_wen_raw = 1'b1;
        reg_dst     = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 4'd6;
        pc_write_cond = 1'b1;
        pc_src        = 2'd1;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
      end
      IWB: reg_wen_raw = 1'b1;
      default: ;
    endcase
  end

  // Write strobes are gated by reset so an aborted instruction never commits.
  assign pc_en       = reset & (pc_write | (pc_write_cond & zero));
  assign mem_wen     = reset & mem_wen_raw;
  assign reg_wen     = reset & reg_wen_raw;
  assign ir_write    = reset & ir_write_raw;
  assign state       = state_q;
  assign instr_count = count_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed cases plus random instruction
// streams against a table-driven reference of per-state controls.
module tb_mc_control;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero;
  logic        pc_en, i_or_d, mem_ren, mem_wen, ir_write, reg_dst;
  logic        mem_to_reg, reg_wen, alu_src_a, illegal;
  logic [1:0]  pc_src, alu_src_b;
  logic [3:0]  alu_op, state;
  logic [31:0] instr_count;

  mc_control dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .pc_src(pc_src), .i_or_d(i_or_d), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_wen(reg_wen), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
    .instr_count(instr_count), .illegal(illegal)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pw, pwc;
    logic [1:0] pc_src;
    logic       i_or_d, mem_ren, mem_wen, ir_write, reg_dst, mem_to_reg, reg_wen, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
  } ctl_t;

  ctl_t                 tbl [16];
  int unsigned          fop [bit [5:0]];
  int unsigned          n_checks = 0;
  int unsigned          n_fails  = 0;
  logic [31:0]          exp_count;
  logic                 exp_ill;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_op(input logic [5:0] op);
    return op == 6'h23 || op == 6'h2B || op == 6'h00 || op == 6'h04 ||
           op == 6'h02 || op == 6'h08;
  endfunction

  // zmode: 0/1 force zero, 2 randomizes it every cycle
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
    int   seq [$];
    bit   bad;
    ctl_t e;
    logic [16:0] obs, expv;
    opcode = op;
    funct  = fn;
    bad    = 1'b0;
    case (op)
      6'h23: seq = '{0, 1, 2, 3, 4};
      6'h2B: seq = '{0, 1, 2, 5};
      6'h04: seq = '{0, 1, 8};
      6'h02: seq = '{0, 1, 9};
      6'h08: seq = '{0, 1, 10, 11};
      6'h00: begin
        if (fop.exists(fn)) seq = '{0, 1, 6, 7};
        else begin seq = '{0, 1, 6}; bad = 1'b1; end
      end
      default: begin seq = '{0, 1}; bad = 1'b1; end
    endcase
    foreach (seq[i]) begin
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      #1;
      e = tbl[seq[i]];
      if (seq[i] == 6) e.alu_op = fop.exists(fn) ? 4'(fop[fn]) : 4'd0;
      expv = {e.pw | (e.pwc & zero), e.pc_src, e.i_or_d, e.mem_ren, e.mem_wen,
              e.ir_write, e.reg_dst, e.mem_to_reg, e.reg_wen, e.alu_src_a,
              e.alu_src_b, e.alu_op};
      obs  = {pc_en, pc_src, i_or_d, mem_ren, mem_wen, ir_write, reg_dst,
              mem_to_reg, reg_wen, alu_src_a, alu_src_b, alu_op};
      chk($sformatf("state op=%h step%0d", op, i), 64'(state), 64'(seq[i]));
      chk($sformatf("ctl op=%h fn=%h st=%0d", op, fn, seq[i]), 64'(obs), 64'(expv));
      chk("ren_wen_exclusive", 64'(mem_ren & mem_wen), 64'd0);
      if (i == 0) begin
        chk("instr_count", 64'(instr_count), 64'(exp_count));
        chk("illegal", 64'(illegal), 64'(exp_ill));
      end
      @(posedge clock);
      #1;
    end
    exp_count = exp_count + 32'd1;
    if (bad) exp_ill = 1'b1;
  endtask

  initial begin
    logic [5:0] rop, rfn;
    logic [5:0] functs [6];
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    fop[6'h20] = 2; fop[6'h22] = 6; fop[6'h24] = 0;
    fop[6'h25] = 1; fop[6'h2A] = 7; fop[6'h27] = 12;
    foreach (tbl[i]) tbl[i] = '0;
    //          pw pwc src iod ren wen irw dst m2r rwe asa asb op
    tbl[0]  = '{1, 0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd1, 4'd2};
    tbl[1]  = '{0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 4'd2};
    tbl[2]  = '{0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 4'd2};
    tbl[3]  = '{0, 0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0};
    tbl[4]  = '{0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 4'd0};
    tbl[5]  = '{0, 0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 4'd0};
    tbl[6]  = '{0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 4'd0};
    tbl[7]  = '{0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 4'd0};
    tbl[8]  = '{0, 1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 4'd6};
    tbl[9]  = '{1, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0};
    tbl[10] = '{0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 4'd2};
    tbl[11] = '{0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 4'd0};

    reset = 1'b0; opcode = 6'h2B; funct = 6'h00; zero = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    // walk sw into MEMWR, then abort it with reset
    repeat (3) begin @(posedge clock); #1; end
    chk("pre_reset_state", 64'(state), 64'd5);
    chk("pre_reset_mem_wen", 64'(mem_wen), 64'd1);
    reset = 1'b0;
    #1;
    chk("reset_gates_mem_wen", 64'(mem_wen), 64'd0);
    repeat (3) begin @(posedge clock); #1; end
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_count", 64'(instr_count), 64'd0);
    chk("reset_illegal", 64'(illegal), 64'd0);
    chk("reset_ir_write", 64'(ir_write), 64'd0);
    chk("reset_pc_en", 64'(pc_en), 64'd0);
    reset = 1'b1;
    exp_count = '0;
    exp_ill   = 1'b0;

    run_instr(6'h23, 6'h00, 2);
    chk("count_after_lw", 64'(instr_count), 64'd1);
    foreach (functs[i]) run_instr(6'h00, functs[i], 2);
    run_instr(6'h04, 6'h00, 1);
    run_instr(6'h04, 6'h00, 0);
    run_instr(6'h3F, 6'h00, 2);
    chk("illegal_set", 64'(illegal), 64'd1);
    run_instr(6'h2B, 6'h00, 2);
    chk("illegal_sticky", 64'(illegal), 64'd1);
    run_instr(6'h00, 6'h3E, 2);
    run_instr(6'h08, 6'h00, 2);

    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    exp_count = 32'hFFFF_FFFF;
    run_instr(6'h02, 6'h00, 2);
    chk("count_wrap", 64'(instr_count), 64'd0);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 7))
        0: rop = 6'h23;
        1: rop = 6'h2B;
        2, 3: rop = 6'h00;
        4: rop = 6'h04;
        5: rop = 6'h02;
        6: rop = 6'h08;
        default: begin
          rop = 6'($urandom);
          while (legal_op(rop)) rop = 6'($urandom);
        end
      endcase
      rfn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
      run_instr(rop, rfn, 2);
    end
    #1;
    chk("final_count", 64'(instr_count), 64'(exp_count));
    chk("final_illegal", 64'(illegal), 64'(exp_ill));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle MIPS control unit. A Moore state machine decodes the fetched instruction's opcode/funct and sequences the datapath one step per clock. It drives the ALU `op` code, the RegFile write enable, the Memory `ren`/`wen` strobes, the PC update and the datapath mux selects. It sits directly upstream of the ALU, RegFile, Memory and PC register, and keeps a retired-instruction counter and a sticky illegal-opcode flag.

## Interface
- No parameters; all widths fixed.
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-low; sampled on posedge `clock`.
- `opcode` in 6: instruction bits [31:26] from the instruction register.
- `funct` in 6: instruction bits [5:0].
- `zero` in 1: ALU zero flag.
- `pc_en` out 1: PC load enable, `pc_write | (pc_write_cond & zero)`.
- `pc_src` out 2: PC source select. 0 = ALU result, 1 = ALUOut register, 2 = jump target.
- `i_or_d` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_ren` out 1: Memory read enable.
- `mem_wen` out 1: Memory write enable.
- `ir_write` out 1: instruction register load.
- `reg_dst` out 1: write register select. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write data select. 0 = ALUOut, 1 = MDR.
- `reg_wen` out 1: RegFile write enable.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = register A.
- `alu_src_b` out 2: ALU B select. 0 = register B, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- `alu_op` out 4: ALU op code. 0 = and, 1 = or, 2 = add, 6 = sub, 7 = slt, 12 = nor.
- `state` out 4: current state, for debug.
- `instr_count` out 32: retired-instruction counter.
- `illegal` out 1: sticky flag, set on an unsupported opcode or funct.

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - REXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11
- FETCH: `mem_ren`=1, `ir_write`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=2, `pc_write`=1, `pc_src`=0. Next state DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=3, `alu_op`=2 (precomputes the branch target). Next state by opcode:
  - 0x23 (lw) or 0x2B (sw) → MEMADR
  - 0x00 → REXEC
  - 0x04 (beq) → BRANCH
  - 0x02 (j) → JUMP
  - 0x08 (addi) → IEXEC
  - any other opcode → FETCH with `illegal` set
- MEMADR: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=2. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_ren`=1, `i_or_d`=1. Next state MEMWB.
- MEMWB: `reg_wen`=1, `reg_dst`=0, `mem_to_reg`=1. Next state FETCH.
- MEMWR: `mem_wen`=1, `i_or_d`=1. Next state FETCH.
- REXEC: `alu_src_a`=1, `alu_src_b`=0. `alu_op` from funct:
  - 0x20 → 2, 0x22 → 6, 0x24 → 0, 0x25 → 1, 0x2A → 7, 0x27 → 12
  - any other funct: `alu_op`=0, `illegal` set, next state FETCH (no writeback)
  - valid funct: next state RWB
- RWB: `reg_wen`=1, `reg_dst`=1, `mem_to_reg`=0. Next state FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=6, `pc_write_cond`=1, `pc_src`=1. Next state FETCH.
- JUMP: `pc_write`=1, `pc_src`=2. Next state FETCH.
- IEXEC: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=2. Next state IWB.
- IWB: `reg_wen`=1, `reg_dst`=0, `mem_to_reg`=0. Next state FETCH.
- Any output not listed for a state is 0.
- `mem_ren` and `mem_wen` are never both 1. This is an invariant the bench must assert.
- `instr_count` increments by 1 on every transition into FETCH from a state other than FETCH, illegal exits included. It wraps from 0xFFFFFFFF to 0.
- `illegal` is set in the cycle the illegal exit is taken. It clears only on reset.
- Unused state encodings 12–15 go to FETCH on the next clock with all outputs 0.

## Timing
- Reset: when `reset`==0 at a posedge, `state`←FETCH, `instr_count`←0, `illegal`←0.
- While `reset`==0, `pc_en`, `mem_wen`, `reg_wen` and `ir_write` are forced to 0 combinationally. No write occurs during reset even if the state is mid-instruction.
- First fetch happens in the first cycle after `reset` returns to 1.
- Reset asserted mid-instruction aborts the instruction. It is not counted.
- Outputs are Moore (functions of `state`), except:
  - `alu_op` and the REXEC illegal exit also depend on `funct`;
  - `pc_en` also depends on `zero`.
- `opcode`/`funct` must be stable from DECODE until the return to FETCH (the IR is loaded only in FETCH).
- Cycles per instruction:
  - lw 5
  - sw, R-type, addi 4
  - beq, j 3
  - illegal opcode 2; illegal funct 3

## Test plan
- Reset: hold `reset`=0 for 3 clocks with `state` forced to MEMWR → `state`=0, `mem_wen`=0, `instr_count`=0, `illegal`=0.
- lw (opcode 0x23) → state sequence 0,1,2,3,4,0. `mem_ren`=1 in states 0 and 3; `reg_wen`=1 only in state 4 with `mem_to_reg`=1. `instr_count`=1.
- R-type, each funct in turn (0x20, 0x22, 0x24, 0x25, 0x2A, 0x27) → `alu_op` in REXEC is 2, 6, 0, 1, 7, 12 respectively. `reg_wen`=1 in RWB with `reg_dst`=1.
- beq: with `zero`=1 → `pc_en`=1 in BRANCH with `pc_src`=1. With `zero`=0 → `pc_en`=0 in BRANCH. Both take 3 cycles.
- Illegal opcode 0x3F → sequence 0,1,0. `illegal`=1 and stays 1 through a following valid sw (0x2B), which completes normally with `mem_wen`=1 in state 5.
- Preload `instr_count`=0xFFFFFFFF via force, run j (0x02) → `instr_count`=0. Over the whole run `mem_ren & mem_wen` is never 1.
